// File: rtl/jk_bank_sched.sv
// jk_bank_sched: round-robin scheduler sharing a bank of N_FF JK cells between two requesters.
// Define JK_TOGGLE_CNT_EN to add toggle_cnt, a saturating count of applied in-range toggles.
module jk_bank_sched #(
  parameter int N_FF   = 4,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [1:0]        req0_op,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [1:0]        req1_op,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic              err,
`ifdef JK_TOGGLE_CNT_EN
  output logic [CNT_W-1:0]  toggle_cnt,
`endif
  output logic [N_FF-1:0]   q,
  output logic [N_FF-1:0]   q_bar
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [ADDR_W:0] NFF = (ADDR_W+1)'(N_FF);

  state_t            state;
  logic [1:0]        lat_op;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_id;
  logic              last_id;
  logic              grant0;
  logic              grant1;
  logic              in_range;
  logic [N_FF-1:0]   q_nxt;

  // last_id resets to 1 so that req0 wins the first contended arbitration
  assign grant0 = req0_valid & (~req1_valid | last_id);
  assign grant1 = req1_valid & (~req0_valid | ~last_id);

  // gated by rst so readys stay low while reset is held with valids asserted
  assign req0_ready = rst & (state == IDLE) & grant0;
  assign req1_ready = rst & (state == IDLE) & grant1;

  assign in_range = ({1'b0, lat_addr} < NFF);
  assign q_bar    = ~q;

  always_comb begin
    q_nxt = q;
    for (int i = 0; i < N_FF; i++) begin
      if (lat_addr == ADDR_W'(i)) begin
        q_nxt[i] = (lat_op[1] & ~q[i]) | (~lat_op[0] & q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lat_op   <= 2'b00;
      lat_addr <= '0;
      lat_id   <= 1'b0;
      last_id  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_id  <= 1'b0;
      err      <= 1'b0;
      q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            state    <= DRIVE;
            busy     <= 1'b1;
            lat_id   <= req1_ready;
            last_id  <= req1_ready;
            lat_op   <= req1_ready ? req1_op : req0_op;
            lat_addr <= req1_ready ? req1_addr : req0_addr;
          end
        end
        DRIVE: begin
          state   <= DONE;
          q       <= q_nxt;
          done    <= 1'b1;
          done_id <= lat_id;
          err     <= ~in_range;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JK_TOGGLE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toggle_cnt <= '0;
    end else if (state == DRIVE && lat_op == 2'b11 && in_range && toggle_cnt != '1) begin
      toggle_cnt <= toggle_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: a 4-cell and a 3-cell instance share stimulus and are
// compared against a command-level reference model of the JK bank.
module tb_jk_bank_sched;

`ifdef JK_TOGGLE_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic v0, v1;
  logic [1:0] op0, op1, a0, a1;
  logic r0, r1, busy, done, done_id, err;
  logic s_r0, s_r1, s_busy, s_done, s_done_id, s_err;
  logic [3:0] q, qb;
  logic [2:0] s_q, s_qb;
`ifdef JK_TOGGLE_CNT_EN
  logic [CW-1:0] tc, s_tc;
`endif

  // model state
  int         m_phase;   // 0 idle, 1 command in flight, 2 completion cycle
  logic       m_last, m_id;
  logic [1:0] m_op, m_addr;
  logic [3:0] m4;
  logic [2:0] m3;
  int         mc4, mc3;
  int         cyc;
  int         errors, checks;

  always #5 clk = ~clk;

  jk_bank_sched #(.N_FF(4), .ADDR_W(2), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_op(op0), .req0_addr(a0), .req0_ready(r0),
    .req1_valid(v1), .req1_op(op1), .req1_addr(a1), .req1_ready(r1),
    .busy(busy), .done(done), .done_id(done_id), .err(err),
`ifdef JK_TOGGLE_CNT_EN
    .toggle_cnt(tc),
`endif
    .q(q), .q_bar(qb)
  );

  jk_bank_sched #(.N_FF(3), .ADDR_W(2), .CNT_W(CW)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_op(op0), .req0_addr(a0), .req0_ready(s_r0),
    .req1_valid(v1), .req1_op(op1), .req1_addr(a1), .req1_ready(s_r1),
    .busy(s_busy), .done(s_done), .done_id(s_done_id), .err(s_err),
`ifdef JK_TOGGLE_CNT_EN
    .toggle_cnt(s_tc),
`endif
    .q(s_q), .q_bar(s_qb)
  );

  function automatic logic jk(input logic [1:0] op, input logic qv);
    case (op)
      2'b00:   return qv;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~qv;
    endcase
  endfunction

  // {req1 wins, req0 wins} for the current inputs
  function automatic logic [1:0] exp_rdy();
    if (!rst || m_phase != 0) return 2'b00;
    return {v1 & (!v0 || !m_last), v0 & (!v1 || m_last)};
  endfunction

  task automatic m_reset();
    m_phase = 0; m_last = 1'b1; m_id = 1'b0; m_op = 2'b00; m_addr = 2'b00;
    m4 = 4'b0000; m3 = 3'b000; mc4 = 0; mc3 = 0;
  endtask

  // one clock; the model applies command-level rules at the edge, returns at posedge+1
  task automatic tick();
    logic [1:0] g;
    g = exp_rdy();
    @(posedge clk);
    cyc++;
    if (rst) begin
      if (m_phase == 1) begin
        m4[m_addr] = jk(m_op, m4[m_addr]);
        if (m_addr != 2'd3) m3[m_addr] = jk(m_op, m3[m_addr]);
        if (m_op == 2'b11) begin
          if (mc4 < MAXC) mc4++;
          if (m_addr != 2'd3 && mc3 < MAXC) mc3++;
        end
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else if (g != 2'b00) begin
        m_phase = 1;
        m_id    = g[1];
        m_last  = g[1];
        m_op    = g[1] ? op1 : op0;
        m_addr  = g[1] ? a1 : a0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    v0 = 1'b1; v1 = 1'b1; op0 = 2'b11; op1 = 2'b10; a0 = 2'd0; a1 = 2'd1;
    rst = 1'b0; m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL reset_q: got %b want 0000", q); end
    checks++; if (qb !== 4'b1111) begin errors++; $display("FAIL reset_qbar: got %b want 1111", qb); end
    checks++; if ({r1, r0} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {r1, r0}); end
    checks++; if (done !== 1'b0 || err !== 1'b0 || done_id !== 1'b0) begin errors++; $display("FAIL reset_done: got done=%b err=%b id=%b want 0", done, err, done_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (s_q !== 3'b000 || s_qb !== 3'b111) begin errors++; $display("FAIL reset_q3: got %b/%b want 000/111", s_q, s_qb); end
`ifdef JK_TOGGLE_CNT_EN
    checks++; if (tc !== '0) begin errors++; $display("FAIL reset_tcnt: got %0d want 0", tc); end
`endif
    v0 = 1'b0; v1 = 1'b0; rst = 1'b1;
    #1;
  endtask

  task automatic test_single();
    v0 = 1'b1; op0 = 2'b10; a0 = 2'd2;
    #1;
    checks++; if ({r1, r0} !== exp_rdy()) begin errors++; $display("FAIL single_ready: got %b want %b", {r1, r0}, exp_rdy()); end
    tick(); v0 = 1'b0; #1;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_drive: got busy=%b done=%b want 1/0", busy, done); end
    tick();
    checks++; if (q !== m4) begin errors++; $display("FAIL single_q: got %b want %b", q, m4); end
    checks++; if (done !== 1'b1 || done_id !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL single_done: got done=%b id=%b err=%b want 1/0/0", done, done_id, err); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_sequence();
    logic [1:0] ops [5] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b11};
    logic       expq [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int ndone = 0;
    for (int i = 0; i < 5; i++) begin
      v1 = 1'b1; op1 = ops[i]; a1 = 2'd1;
      #1;
      checks++; if ({r1, r0} !== 2'b10) begin errors++; $display("FAIL seq_ready[%0d]: got %b want 10", i, {r1, r0}); end
      tick(); v1 = 1'b0;
      tick();
      checks++; if (q[1] !== expq[i] || q !== m4) begin errors++; $display("FAIL seq_q[%0d]: got %b want q[1]=%b model %b", i, q, expq[i], m4); end
      checks++; if (done !== 1'b1 || done_id !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL seq_done[%0d]: got done=%b id=%b err=%b want 1/1/0", i, done, done_id, err); end
      if (done === 1'b1) ndone++;
      tick();
    end
    checks++; if (ndone != 5) begin errors++; $display("FAIL seq_count: got %0d want 5", ndone); end
  endtask

  task automatic test_contention();
    int prev_id = -1, prev_cyc = -1, nx = 0;
    logic [1:0] obs;
    v0 = 1'b1; v1 = 1'b1;
    op0 = 2'($urandom); a0 = 2'($urandom); op1 = 2'($urandom); a1 = 2'($urandom);
    for (int c = 0; c < 40 && nx < 8; c++) begin
      #1;
      obs = {r1, r0};
      checks++; if (obs !== exp_rdy()) begin errors++; $display("FAIL cont_ready: got %b want %b", obs, exp_rdy()); end
      checks++; if (obs === 2'b11) begin errors++; $display("FAIL cont_both: got readys %b want never 11", obs); end
      tick();
      if (obs == 2'b01 || obs == 2'b10) begin
        if (prev_id >= 0) begin
          checks++; if (int'(obs[1]) == prev_id) begin errors++; $display("FAIL cont_alt: got id %0d twice want alternate", prev_id); end
          checks++; if (cyc - 1 - prev_cyc != 3) begin errors++; $display("FAIL cont_gap: got %0d cycles want 3", cyc - 1 - prev_cyc); end
        end
        prev_id = int'(obs[1]); prev_cyc = cyc - 1; nx++;
        if (obs[0]) begin op0 = 2'($urandom); a0 = 2'($urandom); end
        else begin op1 = 2'($urandom); a1 = 2'($urandom); end
      end
      checks++; if (q !== m4) begin errors++; $display("FAIL cont_q: got %b want %b", q, m4); end
    end
    checks++; if (nx != 8) begin errors++; $display("FAIL cont_count: got %0d transfers want 8", nx); end
    v0 = 1'b0; v1 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_boundary();
    rst = 1'b0; m_reset(); #2; rst = 1'b1;
    v0 = 1'b1; op0 = 2'b11; a0 = 2'd3;
    #1;
    checks++; if (r0 !== 1'b1 || s_r0 !== 1'b1) begin errors++; $display("FAIL bnd_ready: got %b/%b want 1/1", r0, s_r0); end
    tick(); v0 = 1'b0;
    tick();
    checks++; if (q[3] !== 1'b1 || q !== m4) begin errors++; $display("FAIL bnd_q4: got %b want %b", q, m4); end
    checks++; if (s_q !== 3'b000 || s_q !== m3) begin errors++; $display("FAIL bnd_q3: got %b want 000", s_q); end
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL bnd_err4: got done=%b err=%b want 1/0", done, err); end
    checks++; if (s_done !== 1'b1 || s_err !== 1'b1) begin errors++; $display("FAIL bnd_err3: got done=%b err=%b want 1/1", s_done, s_err); end
    tick();
  endtask

  task automatic test_midreset();
    v1 = 1'b1; op1 = 2'b11; a1 = 2'd0;
    #1;
    checks++; if ({r1, r0} !== exp_rdy()) begin errors++; $display("FAIL mid_ready: got %b want %b", {r1, r0}, exp_rdy()); end
    tick(); v1 = 1'b0; #2;
    rst = 1'b0; m_reset(); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || q !== 4'b0000 || qb !== 4'b1111) begin errors++; $display("FAIL mid_async: got done=%b busy=%b q=%b qb=%b want 0/0/0000/1111", done, busy, q, qb); end
    tick();
    checks++; if (done !== 1'b0 || s_done !== 1'b0) begin errors++; $display("FAIL mid_nodone: got %b/%b want 0/0", done, s_done); end
    rst = 1'b1;
    v0 = 1'b1; op0 = 2'b10; a0 = 2'd1;
    #1;
    checks++; if ({r1, r0} !== 2'b01) begin errors++; $display("FAIL mid_restart: got %b want 01", {r1, r0}); end
    tick(); v0 = 1'b0;
    tick();
    checks++; if (done !== 1'b1 || done_id !== 1'b0 || q !== m4) begin errors++; $display("FAIL mid_served: got done=%b id=%b q=%b want 1/0/%b", done, done_id, q, m4); end
    tick();
  endtask

  task automatic test_toggle_cnt();
`ifdef JK_TOGGLE_CNT_EN
    for (int i = 0; i < 6; i++) begin
      v0 = 1'b1; op0 = 2'b11; a0 = (i == 5) ? 2'd3 : 2'd0;
      #1;
      tick(); v0 = 1'b0;
      tick(); tick();
      checks++; if (tc !== CW'(mc4) || s_tc !== CW'(mc3)) begin errors++; $display("FAIL tcnt[%0d]: got %0d/%0d want %0d/%0d", i, tc, s_tc, mc4, mc3); end
    end
    checks++; if (tc !== 2'd3) begin errors++; $display("FAIL tcnt_sat: got %0d want 3", tc); end
`endif
  endtask

  task automatic test_random();
    logic [1:0] obs;
    for (int c = 0; c < 400; c++) begin
      if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1'b1; op0 = 2'($urandom); a0 = 2'($urandom); end
      if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1'b1; op1 = 2'($urandom); a1 = 2'($urandom); end
      #1;
      obs = {r1, r0};
      checks++; if (obs !== exp_rdy() || {s_r1, s_r0} !== exp_rdy()) begin errors++; $display("FAIL rnd_ready: got %b/%b want %b", obs, {s_r1, s_r0}, exp_rdy()); end
      checks++; if (busy !== (m_phase != 0) || done !== (m_phase == 2)) begin errors++; $display("FAIL rnd_state: got busy=%b done=%b want phase %0d", busy, done, m_phase); end
      if (m_phase == 2) begin
        checks++; if (done_id !== m_id || s_done_id !== m_id) begin errors++; $display("FAIL rnd_id: got %b/%b want %b", done_id, s_done_id, m_id); end
        checks++; if (err !== 1'b0 || s_err !== (m_addr == 2'd3)) begin errors++; $display("FAIL rnd_err: got %b/%b want 0/%b", err, s_err, (m_addr == 2'd3)); end
      end
      checks++; if (q !== m4 || qb !== ~m4 || s_q !== m3 || s_qb !== ~m3) begin errors++; $display("FAIL rnd_q: got %b/%b %b/%b want %b %b", q, qb, s_q, s_qb, m4, m3); end
      tick();
      if (obs[0]) v0 = 1'b0;
      if (obs[1]) v1 = 1'b0;
    end
    v0 = 1'b0; v1 = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; op0 = 2'b00; op1 = 2'b00; a0 = 2'd0; a1 = 2'd0;
    m_reset();
    test_reset();
    test_single();
    test_sequence();
    test_contention();
    test_boundary();
    test_midreset();
    test_toggle_cnt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish within time limit, want finish");
    $fatal(1);
  end

endmodule
